seg_scan_driver: RTL and testbench

- Multiplexed driver for an 8-digit common-anode seven-segment display bank.
- Takes a 32-bit hex value from the core or debug logic. Time-multiplexes one nibble per digit and generates active-low anode selects, segment lines and decimal point.
- Segment encoding is the team's standard active-low hex glyph set.
- New values take effect only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Value/load inputs and scanned display outputs of the seven-segment driver.
// The core side is the master; the driver is the slave.
interface seg_scan_if;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output data_in, dp_in, load, blank_lz,
        input  anode, seg, dp, frame_done
    );

    modport slave (
        input  data_in, dp_in, load, blank_lz,
        output anode, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit common-anode seven-segment driver. Loaded values are
// held pending and only committed at frame wrap, so a frame is never torn.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_data_q, disp_data_d;
    logic [7:0]    disp_dp_q, disp_dp_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic          pend_q, pend_d;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q;

    logic          tick, wrap, in_guard, blank;
    logic [3:0]    cur_nib;
    logic [6:0]    glyph;
    logic [7:0]    zero_from;

    assign tick     = (presc_q == PW'(REFRESH_DIV - 1));
    assign wrap     = tick && (idx_q == 3'(NUM_DIGITS - 1));
    assign in_guard = (int'(presc_q) < GUARD);

    // zero_from[i]: nibble i and every nibble above it are zero
    for (genvar gi = 0; gi < 8; gi++) begin : g_zero
        assign zero_from[gi] = ~|disp_data_q[31:4*gi];
    end

    assign cur_nib = disp_data_q[{idx_q, 2'b00} +: 4];
    assign blank   = bus.blank_lz && (idx_q != 3'd0) && zero_from[idx_q];

    always_comb begin
        glyph = 7'h7F;
        case (cur_nib)
            4'h0: glyph = 7'h01;
            4'h1: glyph = 7'h4F;
            4'h2: glyph = 7'h12;
            4'h3: glyph = 7'h06;
            4'h4: glyph = 7'h4C;
            4'h5: glyph = 7'h24;
            4'h6: glyph = 7'h20;
            4'h7: glyph = 7'h0F;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h04;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h60;
            4'hC: glyph = 7'h31;
            4'hD: glyph = 7'h42;
            4'hE: glyph = 7'h30;
            4'hF: glyph = 7'h38;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
    end

    // A load on the wrap cycle bypasses (and discards) any older pending value.
    always_comb begin
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_d      = pend_q;
        if (wrap) begin
            if (bus.load) begin
                disp_data_d = bus.data_in;
                disp_dp_d   = bus.dp_in;
            end else if (pend_q) begin
                disp_data_d = pend_data_q;
                disp_dp_d   = pend_dp_q;
            end
            pend_d = 1'b0;
        end else if (bus.load) begin
            pend_data_d = bus.data_in;
            pend_dp_d   = bus.dp_in;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        anode_d = in_guard ? 8'hFF : ~(8'h01 << idx_q);
        seg_d   = blank ? 7'h7F : glyph;
        dp_d    = ~disp_dp_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            anode_q      <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= wrap;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a time-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg_scan_driver;
    localparam int RD = 4;
    localparam int GD = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if bus();

    seg_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph_tab [16];

    // Reference model: position in the scan is derived purely from elapsed cycles.
    bit          m_valid = 0;
    int          m_t     = 0;
    logic [31:0] m_disp  = '0;
    logic [7:0]  m_ddp   = '0;
    bit          m_pend  = 0;
    logic [31:0] m_pdata = '0;
    logic [7:0]  m_pdp   = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        int presc, idx;
        bit wrap, blnk;
        logic [31:0] upper;
        @(posedge clk);
        if (rst) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_t = 0; m_disp = '0; m_ddp = '0; m_pend = 0; m_pdata = '0; m_pdp = '0;
            m_valid = 1;
        end else begin
            presc = m_t % RD;
            idx   = (m_t / RD) % 8;
            upper = m_disp >> (4 * idx);
            blnk  = bus.blank_lz && (idx != 0) && (upper == 0);
            e_an  = (presc < GD) ? 8'hFF : ~(8'h01 << idx);
            e_seg = blnk ? 7'h7F : glyph_tab[upper[3:0]];
            e_dp  = ~m_ddp[idx];
            wrap  = (presc == RD - 1) && (idx == 7);
            e_fd  = wrap;
            if (wrap) begin
                if (bus.load) begin
                    m_disp = bus.data_in; m_ddp = bus.dp_in;
                end else if (m_pend) begin
                    m_disp = m_pdata; m_ddp = m_pdp;
                end
                m_pend = 0;
            end else if (bus.load) begin
                m_pdata = bus.data_in; m_pdp = bus.dp_in; m_pend = 1;
            end
            m_t++;
        end
        #1;
        if (m_valid) begin
            cmp("model_anode", {24'h0, bus.anode}, {24'h0, e_an});
            cmp("model_seg",   {25'h0, bus.seg},   {25'h0, e_seg});
            cmp("model_dp",    {31'h0, bus.dp},    {31'h0, e_dp});
            cmp("model_frame_done", {31'h0, bus.frame_done}, {31'h0, e_fd});
        end
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            step();
            if (bus.frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_frame_done: got timeout expected pulse at %0t", $time);
        end
    endtask

    task automatic wait_digit(input int d);
        bit seen = 0;
        logic [7:0] want;
        want = ~(8'h01 << d);
        if (bus.anode === want) seen = 1;
        for (int n = 0; n < 80 && !seen; n++) begin
            step();
            if (bus.anode === want) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_digit%0d: got timeout expected anode %h at %0t", d, want, $time);
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dpv);
        bus.data_in = v; bus.dp_in = dpv; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [55:0] segs);
        logic [55:0] s;
        s = segs;
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            cmp(name, {25'h0, bus.seg}, {25'h0, s[7*d +: 7]});
        end
    endtask

    initial begin
        glyph_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        bus.data_in = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;

        // Reset values and first active anode
        rst = 1'b1;
        repeat (3) step();
        cmp("rst_anode", {24'h0, bus.anode}, 32'hFF);
        cmp("rst_seg",   {25'h0, bus.seg},   32'h7F);
        cmp("rst_dp",    {31'h0, bus.dp},    32'h1);
        cmp("rst_fd",    {31'h0, bus.frame_done}, 32'h0);
        rst = 1'b0;
        step();
        cmp("guard_anode", {24'h0, bus.anode}, 32'hFF);
        step();
        cmp("first_anode", {24'h0, bus.anode}, 32'hFE);

        // Hex glyphs, digit 0 rightmost
        do_load(32'h89AB_CDEF, 8'h01);
        wait_fd();
        wait_digit(0);
        cmp("dp_digit0", {31'h0, bus.dp}, 32'h0);
        check_frame("glyph_89ABCDEF", {7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38});
        cmp("dp_digit7", {31'h0, bus.dp}, 32'h1);
        do_load(32'h0123_4567, 8'h00);
        wait_fd();
        check_frame("glyph_01234567", {7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F});

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        do_load(32'h0000_00A0, 8'h00);
        wait_fd();
        check_frame("lz_A0", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h01});
        do_load(32'h0, 8'h00);
        wait_fd();
        check_frame("lz_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01});
        bus.blank_lz = 1'b0;

        // Deferred commit of a mid-frame load
        do_load(32'h1111_1111, 8'h00);
        wait_fd();
        wait_digit(3);
        do_load(32'h2222_2222, 8'h00);
        for (int d = 4; d < 8; d++) begin
            wait_digit(d);
            cmp("deferred_old", {25'h0, bus.seg}, 32'h4F);
        end
        wait_fd();
        check_frame("deferred_new", {7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12});

        // Load on the exact wrap cycle beats an older pending value
        wait_fd();
        do_load(32'h3, 8'h00);
        repeat (8 * RD - 2) step();
        do_load(32'h5, 8'h00);
        cmp("wrap_fd", {31'h0, bus.frame_done}, 32'h1);
        check_frame("wrap_load", {7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h24});
        wait_fd();
        check_frame("wrap_pend_clear", {7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h24});

        // Reset mid-scan
        wait_digit(5);
        rst = 1'b1;
        step();
        cmp("midrst_anode", {24'h0, bus.anode}, 32'hFF);
        cmp("midrst_seg",   {25'h0, bus.seg},   32'h7F);
        rst = 1'b0;
        step();
        step();
        cmp("restart_anode", {24'h0, bus.anode}, 32'hFE);
        cmp("restart_seg",   {25'h0, bus.seg},   32'h01);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.load = ($urandom_range(0, 5) == 0);
            bus.data_in = $urandom >> $urandom_range(0, 31);
            bus.dp_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            step();
        end
        rst = 1'b0; bus.load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
